mont_exp_ctrl: RTL and testbench
================================

Name: mont_exp_ctrl

Overview:
- Sequencer that computes result = x^e mod m by issuing a chain of Montgomery multiplications to the existing `montgomery` block.
- Acts as the initiator on the multiplier's start/operands/done/result interface; the multiplier is the responder.
- Implements left-to-right square-and-multiply, including conversion into and out of the Montgomery domain (R = 2^1024).
- Sits above the multiplier in the RSA datapath; one multiplier instance per controller.

Parameters:
- WIDTH, 1024, operand/modulus width in bits.
- ELEN_W, 11, width of exponent-length field (must hold WIDTH).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- in_x  in  WIDTH  base, normal domain, < in_m.
- in_e  in  WIDTH  exponent.
- in_e_len  in  ELEN_W  number of significant exponent bits, 0..WIDTH.
- in_m  in  WIDTH  odd modulus.
- in_r_mod_m  in  WIDTH  R mod m.
- in_r2_mod_m  in  WIDTH  R^2 mod m.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  WIDTH  x^e mod m; held until next accepted start.
- overflow  out  1  sticky per run; set if any mm_result[WIDTH] = 1.
- mm_start  out  1  one-cycle pulse to multiplier.
- mm_a  out  WIDTH  multiplier operand A.
- mm_b  out  WIDTH  multiplier operand B.
- mm_m  out  WIDTH  multiplier modulus, = latched m.
- mm_result  in  WIDTH+1  multiplier result.
- mm_done  in  1  multiplier completion pulse.

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE; busy, done, overflow, mm_start = 0; result, mm_a, mm_b, mm_m, internal registers = 0. Reset mid-run aborts immediately; no further mm_start is issued.
- Start acceptance (IDLE, start=1): latch x, e, e_len, m, r_mod_m, r2_mod_m; clear overflow; set bit index k = e_len-1. Start outside IDLE is ignored.
- Register names: A = accumulator, XT = x in Montgomery domain.
- States and transitions:
  - IDLE -> CONV_X on start.
  - CONV_X: issue MM(x, r2); capture XT. Then A := r_mod_m. Next is SQ if e_len > 0, else FROM.
  - SQ: issue MM(A, A); capture A. Next is MUL if e[k] = 1; otherwise FROM if k = 0, else k-1 and SQ.
  - MUL: issue MM(A, XT); capture A. Next is FROM if k = 0, else k-1 and SQ.
  - FROM: issue MM(A, 1); capture into result; go to DONE.
  - DONE: done=1 for one cycle, busy drops the same cycle; go to IDLE.
- Op handshake:
  - Each op is an ISSUE cycle then WAIT.
  - ISSUE: mm_a/mm_b/mm_m are driven from registers and mm_start=1 for exactly one cycle.
  - mm_a/mm_b/mm_m stay stable through WAIT until mm_done is sampled.
  - WAIT: on the first posedge with mm_done=1, capture mm_result[WIDTH-1:0] and OR mm_result[WIDTH] into overflow.
  - The next ISSUE (or DONE) is the immediately following cycle.
  - mm_done is ignored in the ISSUE cycle and in all non-WAIT states.
- Op count per run: 2 + e_len + popcount(e[e_len-1:0]).
- Total latency from start to done: Σ(1 + L_i) + 2 cycles, where L_i = cycles from mm_start to mm_done for op i.
- Edge cases:
  - e_len=0: two ops (CONV_X, FROM); result = 1 mod m.
  - Exponent bits at or above e_len are ignored.
  - k is decremented only on the transition out of SQ/MUL toward SQ; no underflow wrap.
- Overflow policy: result is still the truncated low WIDTH bits.

Test Plan:
- Bench uses a behavioural multiplier returning a·b·2^-1024 mod m with programmable latency (default 5).
- Basic run: m=13, x=5, e=3, e_len=2, bench-computed r/r2 -> result=8, exactly 6 mm_start pulses, done one cycle, busy falls with done.
- Zero exponent: e_len=0, x=7, m=13 -> result=1, exactly 2 mm_start pulses.
- Full-width exponent: 1024-bit odd m, e = all ones, e_len=1024 -> 2050 mm_start pulses, result equals golden model.
- Protocol robustness:
  - start pulsed while busy -> ignored, no latch change.
  - spurious mm_done in IDLE or in an ISSUE cycle -> no capture.
  - mm_a/mm_b stable across a 20-cycle WAIT.
- Reset mid-run: resetn=0 during a WAIT after the 3rd op -> next cycle busy=0, mm_start=0, result=0; a subsequent start with x=5, e=3 yields 8.
- Overflow: model forces mm_result[1024]=1 on the 2nd op -> overflow=1 at done; cleared on the next start.

Source files
------------

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl
//   Modular exponentiation sequencer: result = x^e mod m, computed by issuing a
//   chain of Montgomery multiplications (left-to-right square-and-multiply) to
//   an external montgomery block. Operands enter the Montgomery domain via
//   MM(x, R^2) and leave it via MM(A, 1).
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   start                one-cycle request, sampled only in IDLE
//   in_x/in_e/in_e_len   base, exponent, significant exponent bits (0..WIDTH)
//   in_m                 odd modulus
//   in_r_mod_m           R mod m
//   in_r2_mod_m          R^2 mod m
//   busy                 run in progress (drops in the done cycle)
//   done                 one-cycle pulse, result valid
//   result               x^e mod m, held until overwritten by the next run
//   overflow             sticky per run, OR of every mm_result[WIDTH]
//   mm_start/mm_a/mm_b/mm_m   request side of the multiplier interface
//   mm_result/mm_done         response side of the multiplier interface
//
// state  | meaning
// IDLE   | waiting for start
// CONV_X | XT = MM(x, R^2 mod m)
// SQ     | A = MM(A, A) for exponent bit k
// MUL    | A = MM(A, XT) for exponent bit k
// FROM   | result = MM(A, 1)
// DONE   | done pulse, back to IDLE
//
// Each operation state opens with one ISSUE cycle (mm_start_q = 1) followed
// by WAIT cycles until mm_done; mm_start_q itself marks the ISSUE cycle.
module mont_exp_ctrl #(
  parameter int WIDTH  = 1024,
  parameter int ELEN_W = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_e,
  input  logic [ELEN_W-1:0] in_e_len,
  input  logic [WIDTH-1:0]  in_m,
  input  logic [WIDTH-1:0]  in_r_mod_m,
  input  logic [WIDTH-1:0]  in_r2_mod_m,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              overflow,
  output logic              mm_start,
  output logic [WIDTH-1:0]  mm_a,
  output logic [WIDTH-1:0]  mm_b,
  output logic [WIDTH-1:0]  mm_m,
  input  logic [WIDTH:0]    mm_result,
  input  logic              mm_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONV_X = 3'd1;
  localparam logic [2:0] S_SQ     = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_FROM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ELEN_W-1:0] k_q, k_d;
  logic [WIDTH-1:0]  e_q, e_d;
  logic              elen_nz_q, elen_nz_d;
  logic [WIDTH-1:0]  r_mod_q, r_mod_d;
  logic [WIDTH-1:0]  xt_q, xt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mm_a_q, mm_a_d;
  logic [WIDTH-1:0]  mm_b_q, mm_b_d;
  logic [WIDTH-1:0]  mm_m_q, mm_m_d;
  logic              mm_start_q, mm_start_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;

  logic              in_op;
  logic              capture;
  logic              e_bit;
  logic [WIDTH-1:0]  mm_lo;

  assign in_op   = (state_q == S_CONV_X) || (state_q == S_SQ) ||
                   (state_q == S_MUL) || (state_q == S_FROM);
  // mm_done only counts in WAIT: an operation state outside its ISSUE cycle
  assign capture = in_op && !mm_start_q && mm_done;
  assign e_bit   = |(e_q & (WIDTH'(1) << k_q));
  assign mm_lo   = mm_result[WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    e_d        = e_q;
    elen_nz_d  = elen_nz_q;
    r_mod_d    = r_mod_q;
    xt_d       = xt_q;
    acc_d      = acc_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    mm_m_d     = mm_m_q;
    mm_start_d = 1'b0;
    result_d   = result_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CONV_X;
          e_d        = in_e;
          k_d        = in_e_len - ELEN_W'(1);
          elen_nz_d  = |in_e_len;
          r_mod_d    = in_r_mod_m;
          ovf_d      = 1'b0;
          mm_a_d     = in_x;
          mm_b_d     = in_r2_mod_m;
          mm_m_d     = in_m;
          mm_start_d = 1'b1;
        end
      end
      S_CONV_X: begin
        if (capture) begin
          xt_d    = mm_lo;
          acc_d   = r_mod_q;
          state_d = elen_nz_q ? S_SQ : S_FROM;
        end
      end
      S_SQ: begin
        if (capture) begin
          acc_d = mm_lo;
          if (e_bit) begin
            state_d = S_MUL;
          end else if (k_q == '0) begin
            state_d = S_FROM;
          end else begin
            k_d     = k_q - ELEN_W'(1);
            state_d = S_SQ;
          end
        end
      end
      S_MUL: begin
        if (capture) begin
          acc_d = mm_lo;
          if (k_q == '0) begin
            state_d = S_FROM;
          end else begin
            k_d     = k_q - ELEN_W'(1);
            state_d = S_SQ;
          end
        end
      end
      S_FROM: begin
        if (capture) begin
          result_d = mm_lo;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      ovf_d = ovf_q | mm_result[WIDTH];
    end

    // Load the next operation's operands so they are valid in its ISSUE cycle
    if (capture && (state_d != S_DONE)) begin
      mm_start_d = 1'b1;
      mm_a_d     = acc_d;
      case (state_d)
        S_SQ:    mm_b_d = acc_d;
        S_MUL:   mm_b_d = xt_q;
        default: mm_b_d = WIDTH'(1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      e_q        <= '0;
      elen_nz_q  <= 1'b0;
      r_mod_q    <= '0;
      xt_q       <= '0;
      acc_q      <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_m_q     <= '0;
      mm_start_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      e_q        <= e_d;
      elen_nz_q  <= elen_nz_d;
      r_mod_q    <= r_mod_d;
      xt_q       <= xt_d;
      acc_q      <= acc_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_m_q     <= mm_m_d;
      mm_start_q <= mm_start_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign overflow = ovf_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = mm_m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier responder with
// programmable latency, plus a plain modular-exponentiation golden model.
module tb_mont_exp_ctrl;
  localparam int W  = 1024;
  localparam int EW = 11;
  typedef logic [W:0]     val_t;
  typedef logic [2*W+1:0] wide_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_x = '0, in_e = '0, in_m = '0, in_r_mod_m = '0, in_r2_mod_m = '0;
  logic [EW-1:0] in_e_len = '0;
  logic          busy, done, overflow, mm_start;
  logic [W-1:0]  result, mm_a, mm_b, mm_m;
  logic [W:0]    mm_result;
  logic          mm_done;

  int n_tests = 0, n_fail = 0;
  string cur = "reset";

  // responder controls (written by the main process only)
  int mm_lat = 5;
  int force_ovf_op = 0;
  int spur_req = 0;
  bit spur_issue = 1'b0;
  bit stab_chk = 1'b0;
  // responder state (written by the responder only)
  int ops = 0;
  int ops_base = 0;
  int spur_ack = 0;
  int cnt = 0;
  logic [W-1:0] sav_a, sav_b;
  logic [W:0]   pending;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.WIDTH(W), .ELEN_W(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_e_len(in_e_len), .in_m(in_m),
    .in_r_mod_m(in_r_mod_m), .in_r2_mod_m(in_r2_mod_m),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  task automatic chk(input string tag, input val_t got, input val_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h (low 128 bits)", cur, tag, got[127:0], exp[127:0]);
    end
  endtask

  // a*b*2^-W mod m by W halving steps
  function automatic val_t mont_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    wide_t t;
    t = wide_t'(a) * wide_t'(b);
    for (int i = 0; i < W; i++) begin
      if (t[0]) t = t + wide_t'(m);
      t = t >> 1;
    end
    if (t >= wide_t'(m)) t = t - wide_t'(m);
    return t[W:0];
  endfunction

  function automatic logic [W-1:0] modexp(input logic [W-1:0] x, input logic [W-1:0] e,
                                          input int elen, input logic [W-1:0] m);
    wide_t r;
    r = wide_t'(1) % wide_t'(m);
    for (int i = elen - 1; i >= 0; i--) begin
      r = (r * r) % wide_t'(m);
      if (e[i]) r = (r * wide_t'(x)) % wide_t'(m);
    end
    return r[W-1:0];
  endfunction

  function automatic int popcnt(input logic [W-1:0] e, input int elen);
    int c;
    c = 0;
    for (int i = 0; i < elen; i++) c += int'(e[i]);
    return c;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // responder: acts #1 after each posedge
  initial begin
    mm_done = 1'b0;
    mm_result = '0;
    forever begin
      @(posedge clk);
      #1;
      mm_done = 1'b0;
      if (!resetn) begin
        cnt = 0;
      end else if (spur_req != spur_ack) begin
        mm_done = 1'b1;
        mm_result = '1;
        spur_ack = spur_req;
      end
      if (cnt > 0) begin
        if (stab_chk) begin
          chk("stable_a", val_t'(mm_a), val_t'(sav_a));
          chk("stable_b", val_t'(mm_b), val_t'(sav_b));
        end
        cnt--;
        if (cnt == 0) begin
          mm_done = 1'b1;
          mm_result = pending;
        end
      end
      if (resetn && mm_start) begin
        ops++;
        sav_a = mm_a;
        sav_b = mm_b;
        pending = mont_mul(mm_a, mm_b, mm_m);
        if (ops - ops_base == force_ovf_op) pending[W] = 1'b1;
        cnt = mm_lat;
        if (spur_issue) begin
          mm_done = 1'b1;
          mm_result = '1;
        end
      end
    end
  end

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] e, input int elen, input logic [W-1:0] m);
    wide_t r;
    r = (wide_t'(1) << W) % wide_t'(m);
    @(negedge clk);
    ops_base    = ops;
    in_x        = x;
    in_e        = e;
    in_e_len    = EW'(elen);
    in_m        = m;
    in_r_mod_m  = r[W-1:0];
    r           = (r * r) % wide_t'(m);
    in_r2_mod_m = r[W-1:0];
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] e, input int elen,
                     input logic [W-1:0] m, input int lat, input int glitch_at, input bit exp_ovf);
    logic [W-1:0] exp_res;
    int exp_ops, n;
    bit seen;
    exp_res = modexp(x, e, elen, m);
    exp_ops = 2 + elen + popcnt(e, elen);
    mm_lat  = lat;
    launch(x, e, elen, m);
    chk("busy_after_start", val_t'(busy), val_t'(1));
    chk("ovf_cleared", val_t'(overflow), val_t'(0));
    n = 1;
    seen = 1'b0;
    while (!seen && n < exp_ops * (lat + 1) + 200) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        start = (n == glitch_at);
        if (n == glitch_at) begin
          in_x = ~x; in_e = ~e; in_e_len = '0; in_m = m ^ W'(2);
          in_r_mod_m = '1; in_r2_mod_m = '1;
        end
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      chk("done_timeout", val_t'(0), val_t'(1));
      return;
    end
    chk("latency", val_t'(n), val_t'(exp_ops * (lat + 1) + 1));
    chk("busy_at_done", val_t'(busy), val_t'(0));
    chk("result", val_t'(result), val_t'(exp_res));
    chk("op_count", val_t'(ops - ops_base), val_t'(exp_ops));
    chk("overflow", val_t'(overflow), val_t'(exp_ovf));
    chk("mm_m", val_t'(mm_m), val_t'(m));
    @(negedge clk);
    chk("done_one_cycle", val_t'(done), val_t'(0));
    chk("idle_busy", val_t'(busy), val_t'(0));
  endtask

  initial begin
    logic [W-1:0] m, x, e;
    int k, base;

    repeat (3) @(negedge clk);
    chk("rst_busy", val_t'(busy), val_t'(0));
    chk("rst_done", val_t'(done), val_t'(0));
    chk("rst_ovf", val_t'(overflow), val_t'(0));
    chk("rst_mm_start", val_t'(mm_start), val_t'(0));
    chk("rst_result", val_t'(result), val_t'(0));
    chk("rst_mm_a", val_t'(mm_a), val_t'(0));
    chk("rst_mm_m", val_t'(mm_m), val_t'(0));
    resetn = 1'b1;

    cur = "basic";      run(W'(5), W'(3), 2, W'(13), 5, 0, 1'b0);
    chk("basic_is_8", val_t'(result), val_t'(8));
    cur = "zero_exp";   run(W'(7), rnd_w(), 0, W'(13), 5, 0, 1'b0);
    chk("zero_is_1", val_t'(result), val_t'(1));
    cur = "busy_start"; run(W'(5), W'(3), 2, W'(13), 3, 4, 1'b0);

    cur = "spur_idle";
    @(negedge clk);
    spur_req++;
    repeat (2) @(negedge clk);
    chk("result_kept", val_t'(result), val_t'(8));
    chk("ovf_kept", val_t'(overflow), val_t'(0));
    chk("stay_idle", val_t'(busy), val_t'(0));

    cur = "spur_issue"; spur_issue = 1'b1;
    run(W'(9), W'(11), 4, W'(23), 2, 0, 1'b0);
    spur_issue = 1'b0;

    cur = "stable"; stab_chk = 1'b1;
    run(W'(5), W'(3), 2, W'(13), 20, 0, 1'b0);
    stab_chk = 1'b0;

    cur = "overflow"; force_ovf_op = 2;
    run(W'(6), W'(5), 3, W'(17), 3, 0, 1'b1);
    force_ovf_op = 0;

    cur = "reset_mid";
    mm_lat = 5;
    launch(W'(5), W'(3), 2, W'(13));
    k = 0;
    while (ops - ops_base < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("third_op_seen", val_t'(ops - ops_base >= 3), val_t'(1));
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("busy_low", val_t'(busy), val_t'(0));
    chk("mm_start_low", val_t'(mm_start), val_t'(0));
    chk("result_zero", val_t'(result), val_t'(0));
    resetn = 1'b1;
    base = ops;
    repeat (10) @(negedge clk);
    chk("no_more_ops", val_t'(ops - base), val_t'(0));
    run(W'(5), W'(3), 2, W'(13), 5, 0, 1'b0);
    chk("after_reset_8", val_t'(result), val_t'(8));

    for (int i = 0; i < 4; i++) begin
      cur = $sformatf("random%0d", i);
      m = rnd_w(); m[W-1] = 1'b1; m[0] = 1'b1;
      x = rnd_w() % m;
      e = rnd_w();
      run(x, e, (i == 0) ? 1 : int'($urandom_range(0, 40)), m, int'($urandom_range(1, 4)), 0, 1'b0);
    end

    cur = "full_width";
    m = rnd_w(); m[W-1] = 1'b1; m[0] = 1'b1;
    x = rnd_w() % m;
    run(x, '1, W, m, 5, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
